// File: rtl/iob_rd_seq.sv
// Read-side sequencer for the IO buffer: scans a W x H tile plus a P-wide zero border
// row-major, issuing one read or pad request per accepted position.
module iob_rd_seq #(
    parameter int AW = 12,
    parameter int DW = 8,
    parameter int PW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [AW-1:0] i_base_addr,
    input  logic [AW-1:0] i_line_stride,
    input  logic [DW-1:0] i_width,
    input  logic [DW-1:0] i_height,
    input  logic [PW-1:0] i_pad,
    input  logic          i_ext_en,
    input  logic          i_ready,
    output logic [AW-1:0] o_iob_raddr,
    output logic          o_iob_rd_en,
    output logic          o_iob_pad_en,
    output logic          o_iob_wsel,
    output logic          o_busy,
    output logic          o_done
);

    localparam int CW = 9;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state;
    logic [AW-1:0] stride_q;
    logic [DW-1:0] width_q;
    logic [DW-1:0] height_q;
    logic [PW-1:0] pad_q;
    logic [AW-1:0] row_base;
    logic [AW-1:0] col_addr;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          last_q;

    logic          start_ok;
    logic          zero_size;
    logic          step;

    logic [AW-1:0] s_stride;
    logic [AW-1:0] s_row_base;
    logic [AW-1:0] s_col_addr;
    logic [DW-1:0] s_width;
    logic [DW-1:0] s_height;
    logic [PW-1:0] s_pad;
    logic [CW-1:0] s_col;
    logic [CW-1:0] s_row;

    logic [CW-1:0] p_ext;
    logic [CW-1:0] w_ext;
    logic [CW-1:0] h_ext;
    logic [CW-1:0] pwd_m1;
    logic [CW-1:0] pht_m1;
    logic          col_in;
    logic          row_in;
    logic          interior;
    logic          row_end;
    logic          last_pos;
    logic [AW-1:0] row_nxt;

    assign start_ok  = (state == IDLE) && i_start && !i_ext_en;
    assign zero_size = (i_width == '0) || (i_height == '0);
    assign step      = i_ready && ((start_ok && !zero_size) || (state == RUN && !last_q));

    // Position 0 is evaluated on the start edge itself, so it sees the live config.
    always_comb begin
        s_stride   = stride_q;
        s_width    = width_q;
        s_height   = height_q;
        s_pad      = pad_q;
        s_row_base = row_base;
        s_col_addr = col_addr;
        s_col      = col;
        s_row      = row;
        if (state == IDLE) begin
            s_stride   = i_line_stride;
            s_width    = i_width;
            s_height   = i_height;
            s_pad      = i_pad;
            s_row_base = i_base_addr;
            s_col_addr = i_base_addr;
            s_col      = '0;
            s_row      = '0;
        end
    end

    assign p_ext    = CW'(s_pad);
    assign w_ext    = CW'(s_width);
    assign h_ext    = CW'(s_height);
    assign pwd_m1   = w_ext + (p_ext << 1) - 1'b1;
    assign pht_m1   = h_ext + (p_ext << 1) - 1'b1;
    assign col_in   = (s_col >= p_ext) && (s_col < p_ext + w_ext);
    assign row_in   = (s_row >= p_ext) && (s_row < p_ext + h_ext);
    assign interior = col_in && row_in;
    assign row_end  = (s_col == pwd_m1);
    assign last_pos = row_end && (s_row == pht_m1);
    assign row_nxt  = row_in ? s_row_base + s_stride : s_row_base;

    assign o_iob_wsel = o_busy;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            stride_q     <= '0;
            width_q      <= '0;
            height_q     <= '0;
            pad_q        <= '0;
            row_base     <= '0;
            col_addr     <= '0;
            col          <= '0;
            row          <= '0;
            last_q       <= 1'b0;
            o_iob_raddr  <= '0;
            o_iob_rd_en  <= 1'b0;
            o_iob_pad_en <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            o_iob_rd_en  <= 1'b0;
            o_iob_pad_en <= 1'b0;
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (start_ok) begin
                        stride_q <= i_line_stride;
                        width_q  <= i_width;
                        height_q <= i_height;
                        pad_q    <= i_pad;
                        row_base <= i_base_addr;
                        col_addr <= i_base_addr;
                        col      <= '0;
                        row      <= '0;
                        last_q   <= 1'b0;
                        if (zero_size) begin
                            state  <= FIN;
                            o_done <= 1'b1;
                        end else begin
                            state  <= RUN;
                            o_busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_q) begin
                        state  <= FIN;
                        last_q <= 1'b0;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                FIN: begin
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Issue the current position; these assignments override the start defaults above.
            if (step) begin
                o_iob_rd_en  <= interior;
                o_iob_pad_en <= !interior;
                if (interior) begin
                    o_iob_raddr <= s_col_addr;
                end
                if (last_pos) begin
                    last_q <= 1'b1;
                    col    <= '0;
                    row    <= '0;
                end else if (row_end) begin
                    col      <= '0;
                    row      <= s_row + 1'b1;
                    row_base <= row_nxt;
                    col_addr <= row_nxt;
                end else begin
                    col <= s_col + 1'b1;
                    if (interior) begin
                        col_addr <= s_col_addr + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_rd_seq.sv
// Randomized scoreboard bench for iob_rd_seq: a frame-level model queues the expected
// request stream, a monitor pops it on every DUT request.
module tb_iob_rd_seq;

    typedef struct packed {
        logic        rd;
        logic [11:0] addr;
    } req_t;

    logic        clk;
    logic        rst_n;
    logic        i_start;
    logic [11:0] i_base_addr;
    logic [11:0] i_line_stride;
    logic [7:0]  i_width;
    logic [7:0]  i_height;
    logic [1:0]  i_pad;
    logic        i_ext_en;
    logic        i_ready;
    logic [11:0] o_iob_raddr;
    logic        o_iob_rd_en;
    logic        o_iob_pad_en;
    logic        o_iob_wsel;
    logic        o_busy;
    logic        o_done;

    req_t        exp_q[$];
    logic [11:0] mdl_addr;
    int          total;
    int          bad;
    int          busy_cnt;
    int          last_busy;

    iob_rd_seq #(.AW(12), .DW(8), .PW(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_base_addr   (i_base_addr),
        .i_line_stride (i_line_stride),
        .i_width       (i_width),
        .i_height      (i_height),
        .i_pad         (i_pad),
        .i_ext_en      (i_ext_en),
        .i_ready       (i_ready),
        .o_iob_raddr   (o_iob_raddr),
        .o_iob_rd_en   (o_iob_rd_en),
        .o_iob_pad_en  (o_iob_pad_en),
        .o_iob_wsel    (o_iob_wsel),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream straight from the frame geometry: interior reads, border pads.
    function automatic int build_model(input int base, input int stride, input int w, input int h, input int p);
        int n;
        n = 0;
        if (w != 0 && h != 0) begin
            for (int r = 0; r < h + 2 * p; r++) begin
                for (int c = 0; c < w + 2 * p; c++) begin
                    if (r >= p && r < p + h && c >= p && c < p + w) begin
                        mdl_addr = 12'((base + (r - p) * stride + (c - p)) & 'hFFF);
                        exp_q.push_back('{rd: 1'b1, addr: mdl_addr});
                    end else begin
                        exp_q.push_back('{rd: 1'b0, addr: mdl_addr});
                    end
                    n++;
                end
            end
        end
        return n;
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 1) return ($urandom_range(0, 3) != 0);
        if (mode == 2) return !(k >= 3 && k <= 5);
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (o_iob_rd_en || o_iob_pad_en) begin
                checkOutput("rd_pad_exclusive", 32'(o_iob_rd_en & o_iob_pad_en), 0);
                checkOutput("busy_on_request", 32'(o_busy), 1);
                checkOutput("wsel_on_request", 32'(o_iob_wsel), 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_request: got rd=%0b pad=%0b expected none at %0t",
                             o_iob_rd_en, o_iob_pad_en, $time);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    checkOutput("request_kind", 32'(o_iob_rd_en), 32'(e.rd));
                    checkOutput("request_addr", 32'(o_iob_raddr), 32'(e.addr));
                end
            end
            if (o_busy) busy_cnt++;
            if (o_done) begin
                last_busy = busy_cnt;
                busy_cnt  = 0;
            end
        end
    end

    // Starts one sequence, paces i_ready, and checks done timing and busy length.
    task automatic applyStimulus(input int base, input int stride, input int w, input int h,
                                 input int p, input int mode);
        int n;
        int issued;
        int edges;
        int k;
        n = build_model(base, stride, w, h, p);
        @(negedge clk);
        #1;
        i_base_addr   = 12'(base);
        i_line_stride = 12'(stride);
        i_width       = 8'(w);
        i_height      = 8'(h);
        i_pad         = 2'(p);
        i_start       = 1'b1;
        i_ready       = ready_for(mode, 0);
        @(posedge clk);
        issued = 0;
        edges  = 0;
        if (n > 0) begin
            edges = 1;
            if (i_ready) issued = 1;
        end
        #1;
        i_start       = 1'b0;
        i_base_addr   = 12'($urandom);
        i_line_stride = 12'($urandom);
        i_width       = 8'($urandom);
        i_height      = 8'($urandom);
        i_pad         = 2'($urandom);
        k = 1;
        while (issued < n && k < 4000) begin
            @(negedge clk);
            #1 i_ready = ready_for(mode, k);
            @(posedge clk);
            edges++;
            if (i_ready) issued++;
            k++;
        end
        if (n > 0) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("done_pulse", 32'(o_done), 1);
        checkOutput("busy_at_done", 32'(o_busy), 0);
        checkOutput("wsel_at_done", 32'(o_iob_wsel), 0);
        checkOutput("busy_cycles", 32'(last_busy), 32'(edges));
        checkOutput("all_requests_seen", 32'(exp_q.size()), 0);
        @(negedge clk);
        #1;
        checkOutput("done_single_cycle", 32'(o_done), 0);
        i_ready = 1'b1;
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        busy_cnt      = 0;
        last_busy     = 0;
        mdl_addr      = '0;
        rst_n         = 1'b0;
        i_start       = 1'b0;
        i_base_addr   = '0;
        i_line_stride = '0;
        i_width       = '0;
        i_height      = '0;
        i_pad         = '0;
        i_ext_en      = 1'b0;
        i_ready       = 1'b1;

        #12;
        checkOutput("reset_raddr", 32'(o_iob_raddr), 0);
        checkOutput("reset_rd_en", 32'(o_iob_rd_en), 0);
        checkOutput("reset_pad_en", 32'(o_iob_pad_en), 0);
        checkOutput("reset_wsel", 32'(o_iob_wsel), 0);
        checkOutput("reset_busy", 32'(o_busy), 0);
        checkOutput("reset_done", 32'(o_done), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        applyStimulus('h100, 'h10, 2, 2, 1, 0);
        applyStimulus('hFFE, 'h20, 3, 1, 0, 0);
        applyStimulus('h100, 'h10, 2, 2, 1, 2);
        applyStimulus('h234, 'h10, 0, 5, 2, 0);

        // Start while the bus owns the buffer must be dropped.
        @(negedge clk);
        #1;
        i_ext_en = 1'b1;
        i_width  = 8'd2;
        i_height = 8'd2;
        i_pad    = 2'd1;
        i_start  = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("ext_busy", 32'(o_busy), 0);
            checkOutput("ext_done", 32'(o_done), 0);
            checkOutput("ext_requests", 32'(o_iob_rd_en | o_iob_pad_en), 0);
        end
        i_ext_en = 1'b0;
        applyStimulus('h100, 'h10, 2, 2, 1, 0);

        // Reset in the cycle carrying position 7, then a clean rerun.
        void'(build_model('h100, 'h10, 2, 2, 1));
        @(negedge clk);
        #1;
        i_base_addr   = 12'h100;
        i_line_stride = 12'h10;
        i_width       = 8'd2;
        i_height      = 8'd2;
        i_pad         = 2'd1;
        i_ready       = 1'b1;
        i_start       = 1'b1;
        @(posedge clk);
        #1 i_start = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        checkOutput("pos7_is_pad", 32'(o_iob_pad_en), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_rd_en", 32'(o_iob_rd_en), 0);
        checkOutput("midrun_rst_pad_en", 32'(o_iob_pad_en), 0);
        checkOutput("midrun_rst_busy", 32'(o_busy), 0);
        checkOutput("midrun_rst_raddr", 32'(o_iob_raddr), 0);
        exp_q.delete();
        mdl_addr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 checkOutput("midrun_rst_no_done", 32'(o_done), 0);
        end
        rst_n = 1'b1;
        applyStimulus('h100, 'h10, 2, 2, 1, 0);

        for (int t = 0; t < 20; t++) begin
            applyStimulus(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                          int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
